// File: rtl/mat_mul_job_sched.sv
// Shares one mat_mul engine between two AXI-Stream requesters: round-robin grant,
// forward A then B to the engine, pulse start, then return the results tagged with the owner id.
module mat_mul_job_sched #(
    parameter int DIM_LOG    = 2,
    parameter int SIZE       = (2**DIM_LOG)**2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_reset,

    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                  s00_axis_tvalid,
    input  logic                  s00_axis_tlast,
    output logic                  s00_axis_tready,

    input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                  s01_axis_tvalid,
    input  logic                  s01_axis_tlast,
    output logic                  s01_axis_tready,

    output logic [DATA_WIDTH-1:0] eng_axis_tdata,
    output logic                  eng_axis_tvalid,
    output logic                  eng_axis_tlast,
    input  logic                  eng_axis_tready,
    output logic                  eng_sel,
    output logic                  eng_start,

    input  logic [DATA_WIDTH-1:0] eng_res_tdata,
    input  logic                  eng_res_tvalid,
    input  logic                  eng_res_tlast,
    output logic                  eng_res_tready,

    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tvalid,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tid,
    input  logic                  m00_axis_tready,

    output logic                  grant,
    output logic                  busy,
    output logic [1:0]            job_err
);

    localparam int SIZE_LOG = 2 * DIM_LOG;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        RESULT
    } state_t;

    state_t                state_q, state_d;
    logic [SIZE_LOG-1:0]   beat_cnt_q, beat_cnt_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;

    logic                  loading;
    logic                  in_result;
    logic                  cnt_last;
    logic                  src_valid;
    logic                  src_last;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  in_hs;
    logic                  res_hs;
    logic                  final_beat;

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;

        loading   = (state_q == LOAD_A) || (state_q == LOAD_B);
        in_result = (state_q == RESULT);
        cnt_last  = (beat_cnt_q == SIZE_LOG'(SIZE - 1));

        src_valid = grant_q ? s01_axis_tvalid : s00_axis_tvalid;
        src_last  = grant_q ? s01_axis_tlast  : s00_axis_tlast;
        src_data  = grant_q ? s01_axis_tdata  : s00_axis_tdata;

        // Granted stream is a combinational pass-through while loading
        eng_axis_tdata  = src_data;
        eng_axis_tvalid = loading && src_valid;
        eng_axis_tlast  = loading && cnt_last;
        eng_sel         = (state_q == LOAD_B);
        s00_axis_tready = loading && !grant_q && eng_axis_tready;
        s01_axis_tready = loading &&  grant_q && eng_axis_tready;
        in_hs           = eng_axis_tvalid && eng_axis_tready;
        eng_start       = (state_q == START);

        // Requester tlast is only checked, never used for sequencing
        final_beat = (state_q == LOAD_B) && cnt_last;
        job_err    = 2'b00;
        if (in_hs && (src_last != final_beat)) begin
            job_err[grant_q] = 1'b1;
        end

        m00_axis_tdata  = eng_res_tdata;
        m00_axis_tvalid = in_result && eng_res_tvalid;
        m00_axis_tlast  = in_result && eng_res_tlast;
        m00_axis_tid    = grant_q;
        eng_res_tready  = in_result && m00_axis_tready;
        res_hs          = m00_axis_tvalid && m00_axis_tready;

        grant = grant_q;
        busy  = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (s00_axis_tvalid || s01_axis_tvalid) begin
                    grant_d    = (s00_axis_tvalid && s01_axis_tvalid) ? !last_grant_q
                                                                       : s01_axis_tvalid;
                    beat_cnt_d = '0;
                    state_d    = LOAD_A;
                end
            end
            LOAD_A: begin
                if (in_hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (cnt_last) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (cnt_last) state_d = START;
                end
            end
            START: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (res_hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (cnt_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mat_mul_job_sched.sv
// Directed bench for mat_mul_job_sched with a behavioural 4x4 engine model
// and hand-computed expected results (A = identity, so C equals B).
module tb_mat_mul_job_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] s00_tdata, s01_tdata;
    logic        s00_tvalid, s00_tlast, s01_tvalid, s01_tlast;
    logic        s00_tready, s01_tready;
    logic [31:0] eng_tdata;
    logic        eng_tvalid, eng_tlast, eng_sel, eng_start;
    logic        eng_rdy = 1'b1;
    logic [31:0] eng_res_tdata;
    logic        eng_res_tvalid, eng_res_tlast, eng_res_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tid;
    logic        m_tready = 1'b1;
    logic        grant, busy;
    logic [1:0]  job_err;

    mat_mul_job_sched #(.DIM_LOG(2), .DATA_WIDTH(32)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_reset   (rst),
        .s00_axis_tdata  (s00_tdata),
        .s00_axis_tvalid (s00_tvalid),
        .s00_axis_tlast  (s00_tlast),
        .s00_axis_tready (s00_tready),
        .s01_axis_tdata  (s01_tdata),
        .s01_axis_tvalid (s01_tvalid),
        .s01_axis_tlast  (s01_tlast),
        .s01_axis_tready (s01_tready),
        .eng_axis_tdata  (eng_tdata),
        .eng_axis_tvalid (eng_tvalid),
        .eng_axis_tlast  (eng_tlast),
        .eng_axis_tready (eng_rdy),
        .eng_sel         (eng_sel),
        .eng_start       (eng_start),
        .eng_res_tdata   (eng_res_tdata),
        .eng_res_tvalid  (eng_res_tvalid),
        .eng_res_tlast   (eng_res_tlast),
        .eng_res_tready  (eng_res_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tid    (m_tid),
        .m00_axis_tready (m_tready),
        .grant           (grant),
        .busy            (busy),
        .job_err         (job_err)
    );

    // Behavioural engine: stores A/B by eng_sel, multiplies on eng_start, streams C
    logic [31:0] ea [16];
    logic [31:0] eb [16];
    logic [31:0] ec [16];
    logic [3:0]  ia = 4'd0, ib = 4'd0, ridx = 4'd0;
    logic        running = 1'b0;
    int          cnt_sel0 = 0, cnt_sel1 = 0, cnt_start = 0, tlast_bad = 0;

    function automatic logic [31:0] dot(input int i, input int j);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 4; k++) s = s + ea[i*4+k] * eb[k*4+j];
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ia <= 4'd0; ib <= 4'd0; ridx <= 4'd0; running <= 1'b0;
        end else begin
            if (eng_tvalid && eng_rdy) begin
                if (eng_tlast !== (eng_sel ? (ib == 4'd15) : (ia == 4'd15)))
                    tlast_bad <= tlast_bad + 1;
                if (!eng_sel) begin
                    ea[ia] <= eng_tdata; ia <= ia + 4'd1; cnt_sel0 <= cnt_sel0 + 1;
                end else begin
                    eb[ib] <= eng_tdata; ib <= ib + 4'd1; cnt_sel1 <= cnt_sel1 + 1;
                end
            end
            if (eng_start) begin
                cnt_start <= cnt_start + 1;
                running   <= 1'b1;
                ridx      <= 4'd0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        ec[i*4+j] <= dot(i, j);
            end else if (running && eng_res_tready) begin
                ridx <= ridx + 4'd1;
                if (ridx == 4'd15) running <= 1'b0;
            end
        end
    end

    assign eng_res_tvalid = running;
    assign eng_res_tdata  = ec[ridx];
    assign eng_res_tlast  = running && (ridx == 4'd15);

    // Monitors
    logic [31:0] res_data [$];
    bit          res_tid  [$];
    bit          res_last [$];
    int          err0_cnt = 0, err1_cnt = 0, err_both = 0, viol = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                res_data.push_back(m_tdata);
                res_tid.push_back(m_tid);
                res_last.push_back(m_tlast);
            end
            if (job_err == 2'b01) err0_cnt <= err0_cnt + 1;
            if (job_err == 2'b10) err1_cnt <= err1_cnt + 1;
            if (job_err == 2'b11) err_both <= err_both + 1;
            if ((!busy && (s00_tready || s01_tready)) ||
                (busy && !grant && s01_tready) || (busy && grant && s00_tready))
                viol <= viol + 1;
        end
    end

    bit after_busy [$];
    bit after_grant [$];
    bit prev_busy = 1'b0, pend = 1'b0;
    always @(negedge clk) begin
        if (pend) begin
            after_busy.push_back(busy);
            after_grant.push_back(grant);
        end
        pend      <= prev_busy && !busy;
        prev_busy <= busy;
    end

    bit toggle = 1'b0;
    always @(negedge clk) begin
        if (toggle) begin
            m_tready <= ~m_tready;
            eng_rdy  <= ~eng_rdy;
        end else begin
            m_tready <= 1'b1;
            eng_rdy  <= 1'b1;
        end
    end

    // Checking helpers
    int n_cmp = 0, n_err = 0, drv_timeout = 0;
    bit abort = 1'b0;
    int b_sel0, b_sel1, b_start, b_err0, b_err1, b_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_sel0 = cnt_sel0; b_sel1 = cnt_sel1; b_start = cnt_start;
        b_err0 = err0_cnt; b_err1 = err1_cnt; b_res = res_data.size();
    endtask

    task automatic job_counts(input string tag, input int njobs, input int e0, input int e1);
        check({tag, "_sel0_beats"}, 32'(cnt_sel0 - b_sel0), 32'(16 * njobs));
        check({tag, "_sel1_beats"}, 32'(cnt_sel1 - b_sel1), 32'(16 * njobs));
        check({tag, "_starts"},     32'(cnt_start - b_start), 32'(njobs));
        check({tag, "_err0"},       32'(err0_cnt - b_err0), 32'(e0));
        check({tag, "_err1"},       32'(err1_cnt - b_err1), 32'(e1));
    endtask

    task automatic drive(input int r, input logic [31:0] base, input int tl_mid, input bit tl_final);
        int          i, t;
        bit          hs, tl;
        logic [31:0] d;
        i = 0; t = 0;
        @(negedge clk);
        while (i < 32 && t < 3000) begin
            d  = (i < 16) ? ((i % 5 == 0) ? 32'd1 : 32'd0) : base + 32'(i - 16);
            tl = (i == tl_mid) || (i == 31 && tl_final);
            if (r == 0) begin s00_tdata = d; s00_tvalid = 1'b1; s00_tlast = tl; end
            else        begin s01_tdata = d; s01_tvalid = 1'b1; s01_tlast = tl; end
            #1;
            if (abort) break;
            hs = (r == 0) ? s00_tready : s01_tready;
            @(negedge clk);
            if (hs) i++;
            t++;
        end
        if (t >= 3000) drv_timeout++;
        if (r == 0) begin s00_tvalid = 1'b0; s00_tlast = 1'b0; end
        else        begin s01_tvalid = 1'b0; s01_tlast = 1'b0; end
    endtask

    task automatic wait_done(input string tag, input int target);
        int t;
        t = 0;
        while ((res_data.size() < target || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_result_count"}, 32'(res_data.size()), 32'(target));
    endtask

    task automatic check_job(input string tag, input int idx, input logic [31:0] base, input bit tid);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_data%0d", tag, k), res_data[idx+k], base + 32'(k));
            check($sformatf("%s_tid%0d", tag, k), 32'(res_tid[idx+k]), 32'(tid));
            check($sformatf("%s_last%0d", tag, k), 32'(res_last[idx+k]), 32'(k == 15));
        end
    endtask

    initial begin
        int n_tr;
        rst = 1'b1;
        s00_tdata = '0; s00_tvalid = 1'b0; s00_tlast = 1'b0;
        s01_tdata = '0; s01_tvalid = 1'b0; s01_tlast = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",        32'(busy), 0);
        check("rst_grant",       32'(grant), 0);
        check("rst_s00_tready",  32'(s00_tready), 0);
        check("rst_s01_tready",  32'(s01_tready), 0);
        check("rst_eng_tvalid",  32'(eng_tvalid), 0);
        check("rst_m_tvalid",    32'(m_tvalid), 0);
        check("rst_eng_start",   32'(eng_start), 0);
        check("rst_res_tready",  32'(eng_res_tready), 0);
        check("rst_job_err",     32'(job_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single s00 job: A = I, B = 1..16
        snap();
        drive(0, 32'd1, -1, 1'b1);
        wait_done("t1", b_res + 16);
        check_job("t1", b_res, 32'd1, 1'b0);
        job_counts("t1", 1, 0, 0);
        check("t1_eng_a0", ea[0], 32'd1);
        check("t1_eng_a1", ea[1], 32'd0);
        check("t1_eng_a5", ea[5], 32'd1);
        check("t1_eng_b0", eb[0], 32'd1);
        check("t1_eng_b15", eb[15], 32'd16);

        // Tie straight after reset: s00 first, then s01
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        snap();
        fork
            drive(0, 32'd1, -1, 1'b1);
            drive(1, 32'd101, -1, 1'b1);
        join
        wait_done("t2a", b_res + 32);
        check_job("t2a_j0", b_res, 32'd1, 1'b0);
        check_job("t2a_j1", b_res + 16, 32'd101, 1'b1);
        job_counts("t2a", 2, 0, 0);

        // s00 alone, then a tie: s01 must win since s00 was last
        snap();
        drive(0, 32'd201, -1, 1'b1);
        wait_done("t2b", b_res + 16);
        check_job("t2b", b_res, 32'd201, 1'b0);
        snap();
        fork
            drive(0, 32'd301, -1, 1'b1);
            drive(1, 32'd401, -1, 1'b1);
        join
        wait_done("t2c", b_res + 32);
        check_job("t2c_j0", b_res, 32'd401, 1'b1);
        check_job("t2c_j1", b_res + 16, 32'd301, 1'b0);

        // Consumer and engine ready toggling every cycle
        snap();
        toggle = 1'b1;
        drive(0, 32'd501, -1, 1'b1);
        wait_done("t3", b_res + 16);
        toggle = 1'b0;
        check_job("t3", b_res, 32'd501, 1'b0);
        job_counts("t3", 1, 0, 0);

        // s01 raises tlast early on A beat 10 (and correctly at the end)
        @(negedge clk);
        snap();
        drive(1, 32'd601, 9, 1'b1);
        wait_done("t4", b_res + 16);
        check_job("t4", b_res, 32'd601, 1'b1);
        job_counts("t4", 1, 0, 1);
        check("t4_err_both", 32'(err_both), 0);

        // s00 omits tlast on the final B beat
        snap();
        drive(0, 32'd701, -1, 1'b0);
        wait_done("t4b", b_res + 16);
        check_job("t4b", b_res, 32'd701, 1'b0);
        job_counts("t4b", 1, 1, 0);

        // Reset in the middle of LOAD_B aborts the job
        snap();
        fork
            drive(0, 32'd999, -1, 1'b1);
            begin
                int t;
                t = 0;
                while ((cnt_sel1 - b_sel1) < 5 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                rst = 1'b1;
                abort = 1'b1;
            end
        join
        check("t5_b_beats_before_rst", 32'(cnt_sel1 - b_sel1), 32'd5);
        @(negedge clk);
        rst = 1'b0;
        abort = 1'b0;
        #1;
        check("t5_busy",       32'(busy), 0);
        check("t5_s00_tready", 32'(s00_tready), 0);
        check("t5_s01_tready", 32'(s01_tready), 0);
        check("t5_eng_tvalid", 32'(eng_tvalid), 0);
        check("t5_m_tvalid",   32'(m_tvalid), 0);
        check("t5_no_results", 32'(res_data.size()), 32'(b_res));
        snap();
        drive(0, 32'd801, -1, 1'b1);
        wait_done("t5", b_res + 16);
        check_job("t5", b_res, 32'd801, 1'b0);
        job_counts("t5", 1, 0, 0);

        // s01 arrives mid-job and waits; grant moves to s01 one cycle after IDLE
        snap();
        n_tr = after_grant.size();
        fork
            drive(0, 32'd901, -1, 1'b1);
            begin
                repeat (3) @(negedge clk);
                drive(1, 32'd1001, -1, 1'b1);
            end
        join
        wait_done("t6", b_res + 32);
        check_job("t6_j0", b_res, 32'd901, 1'b0);
        check_job("t6_j1", b_res + 16, 32'd1001, 1'b1);
        check("t6_grant_after_idle", 32'(after_grant[n_tr]), 32'd1);
        check("t6_busy_after_idle",  32'(after_busy[n_tr]), 32'd1);

        check("ready_violations", 32'(viol), 0);
        check("eng_tlast_errors", 32'(tlast_bad), 0);
        check("driver_timeouts",  32'(drv_timeout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
